// File: rtl/next_pc_unit_if.sv
// Bundle between the IF-stage next-PC unit and its users: predictor/decoder hints and
// EX redirect go in, and the fetch PC plus RAS and mispredict status come out.
interface next_pc_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall_IF;
  logic             predict_taken;
  logic [XLEN-1:0]  imm_pred;
  logic             is_call_IF;
  logic             is_ret_IF;
  logic             mispredict_EX;
  logic [XLEN-1:0]  redirect_pc_EX;
  logic [XLEN-1:0]  PC_out;
  logic [1:0]       pc_src;
  logic             ras_empty;
  logic             ras_full;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output stall_IF, predict_taken, imm_pred, is_call_IF, is_ret_IF,
           mispredict_EX, redirect_pc_EX,
    input  PC_out, pc_src, ras_empty, ras_full, mispredict_cnt
  );

  modport slave (
    input  stall_IF, predict_taken, imm_pred, is_call_IF, is_ret_IF,
           mispredict_EX, redirect_pc_EX,
    output PC_out, pc_src, ras_empty, ras_full, mispredict_cnt
  );
endinterface

// File: rtl/next_pc_unit.sv
// Fetch PC register with next-PC selection (sequential, predicted, RAS return, EX redirect),
// a circular return-address stack and a saturating mispredict counter.
module next_pc_unit #(
  parameter int              XLEN      = 32,
  parameter int              RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              CNT_W     = 16
) (
  input logic           clk,
  input logic           reset,
  next_pc_unit_if.slave bus
);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [1:0]       src_q, src_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;
  logic [XLEN-1:0]  seq_pc;
  logic             ras_has;

  // ptr_q is the next free slot; the top of stack sits one below it (mod depth).
  always_comb begin
    seq_pc  = pc_q + XLEN'(4);
    top_idx = ptr_q - PTR_W'(1);
    ras_has = (occ_q != '0);
    pc_d    = pc_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    occ_d   = occ_q;
    mcnt_d  = mcnt_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;

    if (bus.mispredict_EX) begin
      pc_d   = bus.redirect_pc_EX;
      src_d  = 2'd3;
      mcnt_d = (&mcnt_q) ? mcnt_q : mcnt_q + CNT_W'(1);
    end else if (!bus.stall_IF) begin
      if (bus.is_ret_IF && ras_has) begin
        pc_d  = ras_q[top_idx];
        src_d = 2'd2;
        // A call that is also a return replaces the popped slot in place.
        if (bus.is_call_IF) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          ptr_d = top_idx;
          occ_d = occ_q - OCC_W'(1);
        end
      end else begin
        if (bus.predict_taken) begin
          pc_d  = pc_q + bus.imm_pred;
          src_d = 2'd1;
        end else begin
          pc_d  = seq_pc;
          src_d = 2'd0;
        end
        if (bus.is_call_IF) begin
          wr_en  = 1'b1;
          wr_idx = ptr_q;
          ptr_d  = ptr_q + PTR_W'(1);
          if (occ_q != OCC_W'(RAS_DEPTH)) occ_d = occ_q + OCC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      src_q  <= 2'd0;
      ptr_q  <= '0;
      occ_q  <= '0;
      mcnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      src_q  <= src_d;
      ptr_q  <= ptr_d;
      occ_q  <= occ_d;
      mcnt_q <= mcnt_d;
      if (wr_en) ras_q[wr_idx] <= seq_pc;
    end
  end

  assign bus.PC_out         = pc_q;
  assign bus.pc_src         = src_q;
  assign bus.ras_empty      = (occ_q == '0);
  assign bus.ras_full       = (occ_q == OCC_W'(RAS_DEPTH));
  assign bus.mispredict_cnt = mcnt_q;
endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Owns the fetch PC register and selects the next PC each cycle.
- Next-PC sources: sequential (PC+4), predicted-taken target (PC + imm_pred), return-address-stack (RAS) pop for predicted returns, and EX-stage mispredict redirect.
- Generalises the single-cycle predicted/resolved target mux with a parametrised RAS, stall handling and a mispredict counter.
- Sits at the IF stage, between the predictor/decoder hints and the instruction memory address.

Parameters:
- XLEN, 32, address/data width in bits.
- RAS_DEPTH, 4, number of RAS entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_IF  input  1  hold PC and RAS this cycle.
- predict_taken  input  1  predictor says current fetch is a taken branch/jump.
- imm_pred  input  XLEN  offset for the predicted target, sign-extended by the producer.
- is_call_IF  input  1  current fetch is a call (jal/jalr with rd=x1/x5).
- is_ret_IF  input  1  current fetch is a return (jalr rs1=x1/x5, rd=x0).
- mispredict_EX  input  1  EX resolved a misprediction.
- redirect_pc_EX  input  XLEN  correct PC from EX.
- PC_out  output  XLEN  current fetch PC (registered).
- pc_src  output  2  source of the PC_out value: 0 seq, 1 predicted, 2 RAS, 3 redirect (registered with PC_out).
- ras_empty  output  1  RAS count == 0.
- ras_full  output  1  RAS count == RAS_DEPTH.
- mispredict_cnt  output  CNT_W  saturating count of accepted mispredicts.

Behaviour:
- Reset (synchronous): PC_out=RESET_PC, pc_src=0, RAS top pointer=0, count=0, all entries=0, mispredict_cnt=0. Reset overrides every other input in the same cycle.
- Next-PC priority, highest first:
  1. mispredict_EX: next=redirect_pc_EX, pc_src=3. Applies even when stall_IF=1. No RAS push/pop this cycle. mispredict_cnt increments and saturates at all-ones.
  2. stall_IF: PC_out, pc_src and RAS are unchanged.
  3. is_ret_IF and the RAS is not empty: next = top entry, pc_src=2, pop.
  4. predict_taken: next = PC_out + imm_pred (mod 2^XLEN), pc_src=1.
  5. Otherwise: next = PC_out + 4 (mod 2^XLEN), pc_src=0.
- is_ret_IF with an empty RAS falls through to priority 4 or 5. No pop occurs and no error is raised.
- Call push (only when neither mispredict nor stall is active): write PC_out+4.
  - Push when full: the pointer wraps circularly and overwrites the oldest entry; count stays RAS_DEPTH.
- Call and return in the same cycle:
  - Target comes from the pop.
  - The PC_out+4 value overwrites that same top slot.
  - Count and pointer are unchanged.
  - pc_src=2 if the RAS was non-empty. If it was empty, this is a plain push plus priority 4/5.
- Call with predict_taken: target is PC_out+imm_pred and the push happens as well.
- Pointer arithmetic is modulo RAS_DEPTH. Pop when count=1 gives count=0 and ras_empty=1 the next cycle.
- Latency: all outputs are registered and reflect inputs from the previous edge. Nothing combinational runs from input to output.
- Mispredict does not repair RAS contents. Recovery from wrong-path pushes/pops is out of scope for this block.

Test Plan:
- Reset, then 3 unstalled cycles with no hints → PC_out goes 0x0, 0x4, 0x8, 0xC; pc_src=0; ras_empty=1.
- At PC=0x100, predict_taken=1 with imm_pred=0xFFFF_FFF0 → next PC_out=0x0F0, pc_src=1. Then stall_IF=1 for 2 cycles → PC_out holds 0x0F0.
- Call at 0x200 (predict_taken, imm=0x100) → PC=0x300 and RAS top=0x204. Return at 0x300 → PC=0x204, pc_src=2, ras_empty=1. Return again → falls to PC=0x208.
- RAS_DEPTH=4: push calls from 0x10, 0x20, 0x30, 0x40, 0x50 → ras_full=1. Five returns yield 0x54, 0x44, 0x34, 0x24, then sequential fallback. The 0x14 entry was overwritten.
- mispredict_EX=1 with redirect_pc_EX=0x8000 while stall_IF=1 and is_call_IF=1 → PC_out=0x8000, pc_src=3, RAS unchanged, mispredict_cnt +1. Run with CNT_W=2 and 5 mispredicts → counter stays at 3.
- Assert reset mid-sequence with a non-empty RAS and a pending redirect → next edge gives PC_out=RESET_PC, ras_empty=1, mispredict_cnt=0.
